redcim_operand_sequencer: RTL and testbench

Host-side initiator for the ReDCIM BF16 dot-product macro.
- Accepts BF16 operand pairs one at a time over a valid/ready stream and packs SIZE pairs into the macro's wide BF16_A/BF16_B vectors.
- Issues the one-cycle start pulse, waits the macro's fixed latency, then captures BF16_out.
- Returns the captured result over a valid/ready result stream.

---
 rtl/redcim_operand_sequencer_if.sv | 28 ++
 rtl/redcim_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_redcim_operand_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/redcim_operand_sequencer_if.sv
// Bundled operand, macro and result signals of the ReDCIM operand sequencer.
// The sequencer connects through the slave modport; the host/macro side uses master.
interface redcim_operand_sequencer_if #(
  parameter int SIZE = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_a;
  logic [15:0]          in_b;
  logic                 cim_start;
  logic [16*SIZE-1:0]   cim_A;
  logic [16*SIZE-1:0]   cim_B;
  logic [15:0]          cim_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_data;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, cim_out, res_ready,
    output in_ready, cim_start, cim_A, cim_B, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, cim_out, res_ready,
    input  in_ready, cim_start, cim_A, cim_B, res_valid, res_data, busy
  );
endinterface

// File: rtl/redcim_operand_sequencer.sv
// Packs SIZE BF16 operand pairs, pulses the ReDCIM macro and returns its result.
// Optional REDCIM_SEQ_SPECIAL_BYPASS_EN: Inf/NaN vectors skip the macro and return qNaN.
module redcim_operand_sequencer #(
  parameter int SIZE        = 2,
  parameter int CIM_LATENCY = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  redcim_operand_sequencer_if.slave   bus
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int LAT_W = (CIM_LATENCY > 1) ? $clog2(CIM_LATENCY) : 1;

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    elem_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [16*SIZE-1:0]  cim_a_q;
  logic [16*SIZE-1:0]  cim_b_q;
  logic [15:0]         res_data_p0;

  logic in_ready_c;
  logic cim_start_c;
  logic res_valid_c;
  logic busy_c;
  logic in_xfer;
  logic last_xfer;
  logic res_xfer;
  logic bypass;

  assign in_xfer   = bus.in_valid && in_ready_c;
  assign last_xfer = in_xfer && (elem_cnt == CNT_W'(SIZE - 1));
  assign res_xfer  = res_valid_c && bus.res_ready;

`ifdef REDCIM_SEQ_SPECIAL_BYPASS_EN
  logic special_q;
  logic special_now;

  // Exponent field all-ones marks Inf or NaN on either operand.
  assign special_now = in_xfer && ((bus.in_a[14:7] == 8'hFF) || (bus.in_b[14:7] == 8'hFF));
  assign bypass      = special_q || special_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      special_q <= 1'b0;
    end else if (res_xfer) begin
      special_q <= 1'b0;
    end else if (special_now) begin
      special_q <= 1'b1;
    end
  end
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (last_xfer) state_nxt = bypass ? OUT : START;
      START: state_nxt = WAIT;
      WAIT:  if (lat_cnt == '0) state_nxt = OUT;
      OUT:   if (res_xfer) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    in_ready_c  = rst_n && (state == LOAD);
    cim_start_c = (state == START);
    res_valid_c = (state == OUT);
    busy_c      = (state != LOAD);
  end

  // Operand packing, macro latency count and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt    <= '0;
      lat_cnt     <= '0;
      cim_a_q     <= '0;
      cim_b_q     <= '0;
      res_data_p0 <= '0;
    end else begin
      if (in_xfer) begin
        cim_a_q[{elem_cnt, 4'b0000} +: 16] <= bus.in_a;
        cim_b_q[{elem_cnt, 4'b0000} +: 16] <= bus.in_b;
        elem_cnt <= last_xfer ? '0 : elem_cnt + 1'b1;
      end

      if (state == START) begin
        lat_cnt <= LAT_W'(CIM_LATENCY - 1);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if ((state == WAIT) && (lat_cnt == '0)) begin
        res_data_p0 <= bus.cim_out;
      end else if (last_xfer && bypass) begin
        res_data_p0 <= 16'h7FC0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.cim_start = cim_start_c;
  assign bus.res_valid = res_valid_c;
  assign bus.busy      = busy_c;
  assign bus.cim_A     = cim_a_q;
  assign bus.cim_B     = cim_b_q;
  assign bus.res_data  = res_data_p0;

endmodule

// File: tb/tb_redcim_operand_sequencer.sv
// Scoreboard bench for redcim_operand_sequencer with a fixed-latency stub macro.
module tb_redcim_operand_sequencer;

  localparam int SIZE = 2;
  localparam int LAT  = 8;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   xfer_cyc;
  int   n_chk;
  int   n_fail;
  int   n_xfer;
  int   n_start;
  exp_t sb[$];

  logic [15:0] stub_val;
  logic [15:0] stub_out;
  int          stub_cnt;

  redcim_operand_sequencer_if #(.SIZE(SIZE)) bus();

  redcim_operand_sequencer #(.SIZE(SIZE), .CIM_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.cim_out = stub_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub macro: result valid in the LAT-th cycle after the start edge, garbage otherwise.
  always @(posedge clk) begin
    if (bus.cim_start) begin
      stub_cnt <= 1;
      stub_out <= 16'hDEAD;
    end else if (stub_cnt != 0) begin
      if (stub_cnt == LAT - 1) stub_out <= stub_val;
      else if (stub_cnt == LAT) stub_out <= 16'hDEAD;
      stub_cnt <= (stub_cnt == LAT) ? 0 : stub_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) n_xfer <= n_xfer + 1;
    if (bus.cim_start) n_start <= n_start + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    xfer_cyc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold);
    int          t;
    logic [15:0] d0;
    exp_t        e;
    t = 0;
    @(negedge clk);
    while (!bus.res_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.res_valid) begin
      n_fail++;
      $display("FAIL res_timeout: got res_valid 0 expected 1");
      return;
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got unexpected result %0h expected none", bus.res_data);
      return;
    end
    e = sb.pop_front();
    chk("latency", 64'(cyc - xfer_cyc + 1), 64'(e.lat));
    chk("res_data", bus.res_data, e.data);
    chk("in_ready_out", bus.in_ready, 1'b0);
    d0 = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1'b1);
      chk("hold_data", bus.res_data, d0);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("post_hs_valid", bus.res_valid, 1'b0);
    chk("post_hs_in_ready", bus.in_ready, 1'b1);
    chk("post_hs_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int s0;
    int x0;
    logic [31:0] a_snap;
    logic [31:0] b_snap;
    cyc = 0; n_chk = 0; n_fail = 0; n_xfer = 0; n_start = 0;
    stub_cnt = 0; stub_out = 16'hDEAD; stub_val = 16'h0000;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 16'h0);
    chk("rst_cim_A", bus.cim_A, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Partially loaded vector must be discarded by reset
    send_pair(16'h1111, 16'h2222);
    rst_n = 1'b0;
    #1;
    chk("part_rst_cim_A", bus.cim_A, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic dot product with backpressure
    s0 = n_start;
    stub_val = 16'hC553;
    send_pair(16'hC1BB, 16'h40AA);
    send_pair(16'hC2C0, 16'h42A3);
    sb.push_back('{16'hC553, LAT + 2});
    chk("basic_cim_A", bus.cim_A, 32'hC2C0C1BB);
    chk("basic_cim_B", bus.cim_B, 32'h42A340AA);
    get_result(5);
    chk("basic_starts", 64'(n_start - s0), 64'd1);

    // Gapped input, then operand stability while waiting
    x0 = n_xfer;
    s0 = n_start;
    stub_val = 16'h3F80;
    send_pair(16'h0001, 16'h0002);
    repeat (2) begin @(posedge clk); #1; end
    send_pair(16'h0003, 16'h0004);
    sb.push_back('{16'h3F80, LAT + 2});
    chk("gap_cim_A", bus.cim_A, 32'h00030001);
    chk("gap_cim_B", bus.cim_B, 32'h00040002);
    a_snap = bus.cim_A;
    b_snap = bus.cim_B;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = 16'(16'hF000 + i);
      bus.in_b = 16'(16'hA000 + i);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("stable_cim_A", bus.cim_A, a_snap);
    chk("stable_cim_B", bus.cim_B, b_snap);
    chk("gap_xfers", 64'(n_xfer - x0), 64'd2);
    get_result(0);
    chk("gap_starts", 64'(n_start - s0), 64'd1);

    // Reset asserted while the macro latency is running
    stub_val = 16'h1234;
    send_pair(16'h4000, 16'h4040);
    send_pair(16'h4080, 16'h40C0);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("wrst_cim_start", bus.cim_start, 1'b0);
    chk("wrst_res_valid", bus.res_valid, 1'b0);
    chk("wrst_busy", bus.busy, 1'b0);
    chk("wrst_cim_A", bus.cim_A, 32'h0);
    chk("wrst_cim_B", bus.cim_B, 32'h0);
    chk("wrst_res_data", bus.res_data, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("wrst_rel_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Special-value vector
    s0 = n_start;
    stub_val = 16'h4000;
    send_pair(16'h3F80, 16'h3F80);
    send_pair(16'h7F80, 16'h4000);
`ifdef REDCIM_SEQ_SPECIAL_BYPASS_EN
    sb.push_back('{16'h7FC0, 1});
    get_result(0);
    chk("bypass_starts", 64'(n_start - s0), 64'd0);
`else
    sb.push_back('{16'h4000, LAT + 2});
    get_result(0);
    chk("bypass_starts", 64'(n_start - s0), 64'd1);
`endif

    // Ordinary vector afterwards must take the normal path again
    s0 = n_start;
    stub_val = 16'h4120;
    send_pair(16'h3F80, 16'h3F80);
    send_pair(16'h3F80, 16'h4120);
    sb.push_back('{16'h4120, LAT + 2});
    get_result(2);
    chk("after_starts", 64'(n_start - s0), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
